// File: rtl/uart_byte_receiver.sv
// 8N1 UART receiver: 2-flop input synchronizer, mid-bit sampling FSM and a small
// receive FIFO presented to the consumer through a valid/ready handshake.
module uart_byte_receiver #(
    parameter int SYS_CLK    = 100000000,
    parameter int RATE       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       din,
    output logic [7:0] dout,
    output logic       valid,
    input  logic       ready,
    output logic       frame_error,
    output logic       overrun,
    output logic       busy
);

    localparam int DIV = SYS_CLK / RATE;
    localparam int CW  = $clog2(DIV);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] HALF_LOAD = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(DIV - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t        state, state_next;
    logic [CW-1:0] baud_cnt, baud_cnt_next;
    logic [2:0]    bit_idx, bit_idx_next;
    logic [7:0]    shift_reg, shift_next;
    logic [1:0]    sync_q;
    logic          rx;
    logic          push;
    logic          frame_err_next;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          empty, full, pop, drop, write_en;

    assign rx = sync_q[1];

    // Synchronizer flops reset to the idle (high) line level so reset never fakes a start bit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q    <= 2'b11;
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            sync_q    <= {sync_q[0], din};
            state     <= state_next;
            baud_cnt  <= baud_cnt_next;
            bit_idx   <= bit_idx_next;
            shift_reg <= shift_next;
        end
    end

    always_comb begin
        state_next     = state;
        baud_cnt_next  = baud_cnt;
        bit_idx_next   = bit_idx;
        shift_next     = shift_reg;
        push           = 1'b0;
        frame_err_next = 1'b0;
        case (state)
            IDLE: begin
                if (!rx) begin
                    state_next    = START;
                    baud_cnt_next = HALF_LOAD;
                end
            end
            START: begin
                if (baud_cnt != '0) begin
                    baud_cnt_next = baud_cnt - CW'(1);
                end else if (rx) begin
                    state_next = IDLE;
                end else begin
                    state_next    = DATA;
                    baud_cnt_next = FULL_LOAD;
                    bit_idx_next  = '0;
                end
            end
            DATA: begin
                if (baud_cnt != '0) begin
                    baud_cnt_next = baud_cnt - CW'(1);
                end else begin
                    shift_next    = {rx, shift_reg[7:1]};
                    baud_cnt_next = FULL_LOAD;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (baud_cnt != '0) begin
                    baud_cnt_next = baud_cnt - CW'(1);
                end else if (rx) begin
                    push       = 1'b1;
                    state_next = IDLE;
                end else begin
                    frame_err_next = 1'b1;
                    state_next     = BREAK;
                end
            end
            BREAK: begin
                if (rx) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A pop in the same cycle frees the slot, so a push into a full FIFO is only dropped without one
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop      = valid && ready;
    assign drop     = push && full && !pop;
    assign write_en = push && !drop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (write_en) begin
                mem[wr_ptr[AW-1:0]] <= shift_reg;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            frame_error <= frame_err_next;
            overrun     <= drop;
        end
    end

    assign dout  = mem[rd_ptr[AW-1:0]];
    assign valid = !empty;
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Self-checking bench for uart_byte_receiver: scenario tasks plus randomized frames
// compared against a queue-based model of an 8N1 receiver with a 4-entry buffer.
module tb_uart_byte_receiver;

    localparam int DIV   = 10;
    localparam int DEPTH = 4;
    // sync (2) + idle detect (1) + half bit + 8 data bits + stop bit
    localparam int LAT   = 3 + DIV / 2 + 9 * DIV;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       din   = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] dout;
    logic       valid, frame_error, overrun, busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [7:0] popped [$];
    int         rise_cyc [$];
    int         fe_cnt = 0, ov_cnt = 0, both_cnt = 0, unstable_cnt = 0;
    int         busy_cnt = 0, valid_cnt = 0, last_busy_cyc = -1;
    logic       prev_valid = 1'b0, prev_hold = 1'b0;
    logic [7:0] prev_dout = 8'h00;

    uart_byte_receiver #(.SYS_CLK(1000), .RATE(100), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .din(din), .dout(dout), .valid(valid),
        .ready(ready), .frame_error(frame_error), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observer on the falling edge: records popped bytes, pulses and hold stability
    always @(negedge clk) begin
        if (!reset) begin
            prev_valid = 1'b0;
            prev_hold  = 1'b0;
        end else begin
            if (valid && ready) popped.push_back(dout);
            if (valid && !prev_valid) rise_cyc.push_back(cyc);
            if (valid) valid_cnt++;
            if (frame_error) fe_cnt++;
            if (overrun) ov_cnt++;
            if (frame_error && overrun) both_cnt++;
            if (prev_hold && valid && dout !== prev_dout) unstable_cnt++;
            if (busy) begin
                busy_cnt++;
                last_busy_cyc = cyc;
            end
            prev_valid = valid;
            prev_hold  = valid && !ready;
            prev_dout  = dout;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives start, data (LSB first) and stop bits; optional one-cycle ready pulse at offset pulse_at
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int pulse_at, input int ncyc);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        for (int t = 0; t < ncyc; t++) begin
            din = fr[t / DIV];
            if (pulse_at >= 0) begin
                if (t == pulse_at) ready = 1'b1;
                else if (t == pulse_at + 1) ready = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        if (ncyc >= 10 * DIV) din = 1'b1;
    endtask

    task automatic test_reset;
        n_cmp++;
        if ({dout, valid, frame_error, overrun, busy} !== 12'h000) begin
            n_bad++;
            $display("[TB] FAIL reset_outputs: got %h want 000", {dout, valid, frame_error, overrun, busy});
        end
    endtask

    task automatic test_single;
        int p0, r0, f0, o0, v0, c0, lat;
        logic [7:0] got;
        p0 = popped.size(); r0 = rise_cyc.size(); f0 = fe_cnt; o0 = ov_cnt; v0 = valid_cnt; c0 = cyc;
        ready = 1'b1;
        send_frame(8'h55, 1'b1, -1, 10 * DIV);
        idle(DIV);
        got = (popped.size() > p0) ? popped[p0] : 8'hxx;
        lat = (rise_cyc.size() > r0) ? rise_cyc[r0] - c0 : -1;
        n_cmp++; if (popped.size() - p0 != 1) begin n_bad++; $display("[TB] FAIL single_count: got %0d want 1", popped.size() - p0); end
        n_cmp++; if (got !== 8'h55) begin n_bad++; $display("[TB] FAIL single_byte: got %h want 55", got); end
        n_cmp++; if (valid_cnt - v0 != 1) begin n_bad++; $display("[TB] FAIL single_valid_cycles: got %0d want 1", valid_cnt - v0); end
        n_cmp++; if (lat != LAT) begin n_bad++; $display("[TB] FAIL single_latency: got %0d want %0d", lat, LAT); end
        n_cmp++; if (fe_cnt != f0 || ov_cnt != o0) begin n_bad++; $display("[TB] FAIL single_flags: fe %0d ov %0d want 0 0", fe_cnt - f0, ov_cnt - o0); end
    endtask

    task automatic test_glitch;
        int b0, v0, f0, c1;
        b0 = busy_cnt; v0 = valid_cnt; f0 = fe_cnt;
        ready = 1'b1;
        din = 1'b0;
        idle(3);
        din = 1'b1;
        c1 = cyc;
        idle(2 * DIV);
        n_cmp++; if (busy_cnt <= b0) begin n_bad++; $display("[TB] FAIL glitch_busy_seen: got 0 want 1"); end
        n_cmp++; if (last_busy_cyc - c1 > DIV / 2 + 3) begin n_bad++; $display("[TB] FAIL glitch_busy_drop: got %0d cycles want <= %0d", last_busy_cyc - c1, DIV / 2 + 3); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL glitch_busy_end: got %b want 0", busy); end
        n_cmp++; if (valid_cnt != v0 || fe_cnt != f0) begin n_bad++; $display("[TB] FAIL glitch_no_output: valid %0d fe %0d want 0 0", valid_cnt - v0, fe_cnt - f0); end
    endtask

    task automatic test_break;
        int v0, f0;
        v0 = valid_cnt; f0 = fe_cnt;
        ready = 1'b1;
        send_frame(8'hA3, 1'b0, -1, 9 * DIV);
        din = 1'b0;
        idle(30);
        @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("[TB] FAIL break_busy_low_line: got %b want 1", busy); end
        n_cmp++; if (fe_cnt - f0 != 1) begin n_bad++; $display("[TB] FAIL break_frame_error: got %0d want 1", fe_cnt - f0); end
        @(posedge clk);
        #1;
        din = 1'b1;
        idle(5);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL break_busy_release: got %b want 0", busy); end
        n_cmp++; if (valid_cnt != v0 || fe_cnt - f0 != 1) begin n_bad++; $display("[TB] FAIL break_outputs: valid %0d fe %0d want 0 1", valid_cnt - v0, fe_cnt - f0); end
        idle(DIV);
    endtask

    task automatic test_overrun;
        int p0, o0, f0, u0;
        logic [7:0] exp [$];
        p0 = popped.size(); o0 = ov_cnt; f0 = fe_cnt; u0 = unstable_cnt;
        ready = 1'b0;
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, -1, 10 * DIV);
        n_cmp++; if (ov_cnt != o0) begin n_bad++; $display("[TB] FAIL overrun_early: got %0d want 0", ov_cnt - o0); end
        send_frame(8'h05, 1'b1, -1, 10 * DIV);
        idle(2);
        n_cmp++; if (ov_cnt - o0 != 1) begin n_bad++; $display("[TB] FAIL overrun_pulse: got %0d want 1", ov_cnt - o0); end
        n_cmp++; if (unstable_cnt != u0) begin n_bad++; $display("[TB] FAIL overrun_dout_hold: got %0d changes want 0", unstable_cnt - u0); end
        ready = 1'b1;
        idle(10);
        ready = 1'b0;
        exp = '{8'h01, 8'h02, 8'h03, 8'h04};
        n_cmp++; if (popped.size() - p0 != exp.size()) begin n_bad++; $display("[TB] FAIL overrun_pop_count: got %0d want %0d", popped.size() - p0, exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            n_cmp++;
            if ((popped.size() > p0 + i ? popped[p0 + i] : 8'hxx) !== exp[i]) begin
                n_bad++;
                $display("[TB] FAIL overrun_pop_%0d: got %h want %h", i, popped.size() > p0 + i ? popped[p0 + i] : 8'hxx, exp[i]);
            end
        end
        n_cmp++; if (fe_cnt != f0) begin n_bad++; $display("[TB] FAIL overrun_no_fe: got %0d want 0", fe_cnt - f0); end
    endtask

    task automatic test_full_pop;
        int p0, o0;
        logic [7:0] exp [$];
        p0 = popped.size(); o0 = ov_cnt;
        ready = 1'b0;
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, -1, 10 * DIV);
        send_frame(8'h05, 1'b1, LAT - 1, 10 * DIV);
        idle(2);
        n_cmp++; if (ov_cnt != o0) begin n_bad++; $display("[TB] FAIL full_pop_overrun: got %0d want 0", ov_cnt - o0); end
        ready = 1'b1;
        idle(10);
        ready = 1'b0;
        exp = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        n_cmp++; if (popped.size() - p0 != exp.size()) begin n_bad++; $display("[TB] FAIL full_pop_count: got %0d want %0d", popped.size() - p0, exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            n_cmp++;
            if ((popped.size() > p0 + i ? popped[p0 + i] : 8'hxx) !== exp[i]) begin
                n_bad++;
                $display("[TB] FAIL full_pop_%0d: got %h want %h", i, popped.size() > p0 + i ? popped[p0 + i] : 8'hxx, exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        int p0, f0;
        logic [7:0] got;
        ready = 1'b0;
        send_frame(8'h3C, 1'b1, -1, 10 * DIV);
        idle(2);
        n_cmp++; if (valid !== 1'b1 || dout !== 8'h3C) begin n_bad++; $display("[TB] FAIL reset_mid_preload: got %b/%h want 1/3c", valid, dout); end
        send_frame(8'h7E, 1'b1, -1, 5 * DIV + DIV / 2);
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({dout, valid, frame_error, overrun, busy} !== 12'h000) begin
            n_bad++;
            $display("[TB] FAIL reset_mid_outputs: got %h want 000", {dout, valid, frame_error, overrun, busy});
        end
        din = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(3);
        p0 = popped.size(); f0 = fe_cnt;
        ready = 1'b1;
        send_frame(8'hC4, 1'b1, -1, 10 * DIV);
        idle(DIV);
        got = (popped.size() > p0) ? popped[p0] : 8'hxx;
        n_cmp++; if (popped.size() - p0 != 1 || got !== 8'hC4) begin n_bad++; $display("[TB] FAIL reset_mid_next: got %0d bytes first %h want 1 c4", popped.size() - p0, got); end
        n_cmp++; if (fe_cnt != f0) begin n_bad++; $display("[TB] FAIL reset_mid_fe: got %0d want 0", fe_cnt - f0); end
    endtask

    task automatic test_random;
        int p0, f0, o0, n_err, k, exp_ov;
        logic [7:0] b;
        logic good;
        logic [7:0] exp [$];
        // Streaming with ready held high: every frame with a good stop bit arrives in order
        p0 = popped.size(); f0 = fe_cnt; o0 = ov_cnt; n_err = 0;
        exp.delete();
        ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom);
            good = ($urandom_range(0, 3) != 0);
            if (good) exp.push_back(b); else n_err++;
            send_frame(b, good, -1, 10 * DIV);
            idle($urandom_range(2, 2 * DIV));
        end
        idle(DIV);
        n_cmp++; if (popped.size() - p0 != exp.size()) begin n_bad++; $display("[TB] FAIL rand_stream_count: got %0d want %0d", popped.size() - p0, exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            n_cmp++;
            if ((popped.size() > p0 + i ? popped[p0 + i] : 8'hxx) !== exp[i]) begin
                n_bad++;
                $display("[TB] FAIL rand_stream_%0d: got %h want %h", i, popped.size() > p0 + i ? popped[p0 + i] : 8'hxx, exp[i]);
            end
        end
        n_cmp++; if (fe_cnt - f0 != n_err || ov_cnt != o0) begin n_bad++; $display("[TB] FAIL rand_stream_flags: fe %0d ov %0d want %0d 0", fe_cnt - f0, ov_cnt - o0, n_err); end
        // Bursts with the consumer stalled: only the first DEPTH bytes survive
        for (int r = 0; r < 3; r++) begin
            p0 = popped.size(); o0 = ov_cnt;
            exp.delete();
            k = $urandom_range(1, 6);
            exp_ov = (k > DEPTH) ? k - DEPTH : 0;
            ready = 1'b0;
            for (int i = 0; i < k; i++) begin
                b = 8'($urandom);
                if (i < DEPTH) exp.push_back(b);
                send_frame(b, 1'b1, -1, 10 * DIV);
            end
            idle(2);
            ready = 1'b1;
            idle(10);
            ready = 1'b0;
            n_cmp++; if (ov_cnt - o0 != exp_ov) begin n_bad++; $display("[TB] FAIL rand_burst%0d_overrun: got %0d want %0d", r, ov_cnt - o0, exp_ov); end
            n_cmp++; if (popped.size() - p0 != exp.size()) begin n_bad++; $display("[TB] FAIL rand_burst%0d_count: got %0d want %0d", r, popped.size() - p0, exp.size()); end
            for (int i = 0; i < exp.size(); i++) begin
                n_cmp++;
                if ((popped.size() > p0 + i ? popped[p0 + i] : 8'hxx) !== exp[i]) begin
                    n_bad++;
                    $display("[TB] FAIL rand_burst%0d_%0d: got %h want %h", r, i, popped.size() > p0 + i ? popped[p0 + i] : 8'hxx, exp[i]);
                end
            end
        end
    endtask

    task automatic test_invariants;
        n_cmp++; if (both_cnt != 0) begin n_bad++; $display("[TB] FAIL fe_ov_exclusive: got %0d both-high cycles want 0", both_cnt); end
        n_cmp++; if (unstable_cnt != 0) begin n_bad++; $display("[TB] FAIL dout_stable: got %0d changes want 0", unstable_cnt); end
    endtask

    initial begin
        #2;
        test_reset;
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(3);
        test_single;
        test_glitch;
        test_break;
        test_overrun;
        test_full_pop;
        test_reset_mid;
        test_random;
        test_invariants;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL timeout: got no completion want finish before time limit");
        $fatal(1, "[TB] time limit exceeded");
    end

endmodule
